// File: rtl/ballot_controller.sv
// Polling-session sequencer for the EVM vote counter: officer/voter buttons in,
// one valid/ready cast per released ballot out, plus result-browse index.
module ballot_controller #(
  parameter int N_CAND         = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int LOCK_CYCLES    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      open_poll,
  input  logic                      ballot_release,
  input  logic                      close_poll,
  input  logic                      next_result,
  input  logic [N_CAND-1:0]         v,
  input  logic                      cast_ready,
  output logic                      cast_valid,
  output logic [$clog2(N_CAND)-1:0] cast_idx,
  output logic                      ready_lamp,
  output logic                      armed_lamp,
  output logic                      busy,
  output logic                      result_mode,
  output logic [$clog2(N_CAND)-1:0] result_sel,
  output logic                      invalid_vote,
  output logic                      timeout_pulse,
  output logic [7:0]                ballots_cast
);

  localparam int IDX_W = $clog2(N_CAND);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCK_CYCLES - 1);
  localparam logic [IDX_W-1:0] SEL_LAST = IDX_W'(N_CAND - 1);

  typedef enum logic [2:0] {
    IDLE, READY, ARMED, CAST, LOCK, RESULTS
  } state_t;

  state_t state, state_nxt;

  logic [3:0]       btn, btn_prev, btn_edge;
  logic             open_edge, release_edge, close_edge, next_edge;
  logic             v_onehot, v_multi;
  logic             load_idx, tmo_hit, xfer;
  logic [TMO_W-1:0] tmo_cnt;
  logic [LCK_W-1:0] lck_cnt;

  function automatic logic is_onehot(input logic [N_CAND-1:0] x);
    return (x != '0) && ((x & (x - N_CAND'(1))) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] encode(input logic [N_CAND-1:0] x);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_CAND; i++)
      if (x[i]) idx = IDX_W'(i);
    return idx;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    return (x == SEL_LAST) ? '0 : x + IDX_W'(1);
  endfunction

  assign btn          = {open_poll, ballot_release, close_poll, next_result};
  assign btn_edge     = btn & ~btn_prev;
  assign open_edge    = btn_edge[3];
  assign release_edge = btn_edge[2];
  assign close_edge   = btn_edge[1];
  assign next_edge    = btn_edge[0];
  assign v_onehot     = is_onehot(v);
  assign v_multi      = (v != '0) && !v_onehot;

  // prev resets high so a button held through reset release yields no edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) btn_prev <= '1;
    else       btn_prev <= btn;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_idx  = 1'b0;
    tmo_hit   = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE:    if (open_edge) state_nxt = READY;
      READY: begin
        if (close_edge)        state_nxt = RESULTS;
        else if (release_edge) state_nxt = ARMED;
      end
      ARMED: begin
        if (v_onehot) begin
          state_nxt = CAST;
          load_idx  = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = READY;
          tmo_hit   = 1'b1;
        end
      end
      CAST: begin
        if (cast_ready) begin
          state_nxt = LOCK;
          xfer      = 1'b1;
        end
      end
      // lock counter saturates at its last value, so == acts as >=
      LOCK:    if (lck_cnt == LCK_LAST && v == '0) state_nxt = READY;
      RESULTS: state_nxt = RESULTS;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt       <= '0;
      lck_cnt       <= '0;
      cast_idx      <= '0;
      invalid_vote  <= 1'b0;
      timeout_pulse <= 1'b0;
      ballots_cast  <= '0;
      result_sel    <= '0;
    end else begin
      tmo_cnt       <= (state == ARMED) ? tmo_cnt + TMO_W'(1) : '0;
      if (state != LOCK)          lck_cnt <= '0;
      else if (lck_cnt != LCK_LAST) lck_cnt <= lck_cnt + LCK_W'(1);
      if (load_idx) cast_idx <= encode(v);
      invalid_vote  <= (state_nxt == ARMED) && v_multi;
      timeout_pulse <= tmo_hit;
      if (xfer) ballots_cast <= sat_inc(ballots_cast);
      if (state != RESULTS) result_sel <= '0;
      else if (next_edge)   result_sel <= wrap_inc(result_sel);
    end
  end

  // cast_valid decodes the state so an asynchronous reset drops it at once
  assign cast_valid  = (state == CAST);
  assign ready_lamp  = (state == READY);
  assign armed_lamp  = (state == ARMED);
  assign busy        = (state == CAST) || (state == LOCK);
  assign result_mode = (state == RESULTS);

endmodule

// File: tb/tb_ballot_controller.sv
// Directed bench for ballot_controller: a vector table walked cycle-group by
// cycle-group, plus hand sequences for backpressure, async reset and saturation.
module tb_ballot_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       open_poll, ballot_release, close_poll, next_result;
  logic [3:0] v;
  logic       cast_ready;
  logic       cast_valid;
  logic [1:0] cast_idx;
  logic       ready_lamp, armed_lamp, busy, result_mode;
  logic [1:0] result_sel;
  logic       invalid_vote, timeout_pulse;
  logic [7:0] ballots_cast;

  ballot_controller #(.N_CAND(4), .TIMEOUT_CYCLES(1000), .LOCK_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .open_poll(open_poll), .ballot_release(ballot_release),
    .close_poll(close_poll), .next_result(next_result),
    .v(v), .cast_ready(cast_ready),
    .cast_valid(cast_valid), .cast_idx(cast_idx),
    .ready_lamp(ready_lamp), .armed_lamp(armed_lamp), .busy(busy),
    .result_mode(result_mode), .result_sel(result_sel),
    .invalid_vote(invalid_vote), .timeout_pulse(timeout_pulse),
    .ballots_cast(ballots_cast)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         n;      // cycles to hold these inputs
    logic [3:0] btn;    // {open, release, close, next}
    logic [3:0] v;
    logic       rdy;
    logic [3:0] lamps;  // {ready, armed, busy, result_mode}
    logic       cv;
    logic [1:0] idx;
    logic       inv;
    logic       tp;
    logic [7:0] bc;
    logic [1:0] rs;
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic add(input int n, input logic [3:0] btn, input logic [3:0] vv,
                     input logic rdy, input logic [3:0] lamps, input logic cv,
                     input logic [1:0] idx, input logic inv, input logic tp,
                     input logic [7:0] bc, input logic [1:0] rs);
    vec_t e;
    e.n = n; e.btn = btn; e.v = vv; e.rdy = rdy; e.lamps = lamps; e.cv = cv;
    e.idx = idx; e.inv = inv; e.tp = tp; e.bc = bc; e.rs = rs;
    vq.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [18:0] outs();
    return {ready_lamp, armed_lamp, busy, result_mode, cast_valid, cast_idx,
            invalid_vote, timeout_pulse, ballots_cast, result_sel};
  endfunction

  task automatic do_cast();
    ballot_release = 1'b1; tick(1);
    ballot_release = 1'b0; v = 4'b0001; cast_ready = 1'b1; tick(2);
    v = 4'b0000; cast_ready = 1'b0; tick(16);
  endtask

  logic [1:0] seq [5];

  initial begin
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;

    // first cast, exact 16-cycle lock
    add(2,   4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0, 8'd0, 2'd0);
    add(1,   4'b0110, 4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0, 8'd0, 2'd0);
    add(1,   4'b1000, 4'b0000, 0, 4'b1000, 0, 2'd0, 0, 0, 8'd0, 2'd0);
    add(1,   4'b0000, 4'b0000, 0, 4'b1000, 0, 2'd0, 0, 0, 8'd0, 2'd0);
    add(1,   4'b0100, 4'b0000, 0, 4'b0100, 0, 2'd0, 0, 0, 8'd0, 2'd0);
    add(1,   4'b0000, 4'b0100, 1, 4'b0010, 1, 2'd2, 0, 0, 8'd0, 2'd0);
    add(1,   4'b0000, 4'b0100, 1, 4'b0010, 0, 2'd2, 0, 0, 8'd1, 2'd0);
    add(15,  4'b0000, 4'b0000, 0, 4'b0010, 0, 2'd2, 0, 0, 8'd1, 2'd0);
    add(1,   4'b0000, 4'b0000, 0, 4'b1000, 0, 2'd2, 0, 0, 8'd1, 2'd0);
    // multi-hot then valid; lock held while switch stays on
    add(1,   4'b0100, 4'b0000, 0, 4'b0100, 0, 2'd2, 0, 0, 8'd1, 2'd0);
    add(5,   4'b0000, 4'b0110, 0, 4'b0100, 0, 2'd2, 1, 0, 8'd1, 2'd0);
    add(1,   4'b0000, 4'b0001, 0, 4'b0010, 1, 2'd0, 0, 0, 8'd1, 2'd0);
    add(1,   4'b0000, 4'b0001, 1, 4'b0010, 0, 2'd0, 0, 0, 8'd2, 2'd0);
    add(20,  4'b0000, 4'b0001, 0, 4'b0010, 0, 2'd0, 0, 0, 8'd2, 2'd0);
    add(1,   4'b0000, 4'b0000, 0, 4'b1000, 0, 2'd0, 0, 0, 8'd2, 2'd0);
    // timeout after 1000 armed cycles
    add(1,   4'b0100, 4'b0000, 0, 4'b0100, 0, 2'd0, 0, 0, 8'd2, 2'd0);
    add(999, 4'b0000, 4'b0000, 0, 4'b0100, 0, 2'd0, 0, 0, 8'd2, 2'd0);
    add(1,   4'b0000, 4'b0000, 0, 4'b1000, 0, 2'd0, 0, 1, 8'd2, 2'd0);
    add(1,   4'b0000, 4'b0000, 0, 4'b1000, 0, 2'd0, 0, 0, 8'd2, 2'd0);
    // valid vote on the final armed cycle beats the timeout
    add(1,   4'b0100, 4'b0000, 0, 4'b0100, 0, 2'd0, 0, 0, 8'd2, 2'd0);
    add(999, 4'b0000, 4'b0000, 0, 4'b0100, 0, 2'd0, 0, 0, 8'd2, 2'd0);
    add(1,   4'b0000, 4'b1000, 1, 4'b0010, 1, 2'd3, 0, 0, 8'd2, 2'd0);
    add(1,   4'b0000, 4'b1000, 1, 4'b0010, 0, 2'd3, 0, 0, 8'd3, 2'd0);
    add(16,  4'b0000, 4'b0000, 0, 4'b1000, 0, 2'd3, 0, 0, 8'd3, 2'd0);
    // close and release together: close wins; then browse results
    add(1,   4'b0110, 4'b0000, 0, 4'b0001, 0, 2'd3, 0, 0, 8'd3, 2'd0);
    add(1,   4'b0000, 4'b0000, 0, 4'b0001, 0, 2'd3, 0, 0, 8'd3, 2'd0);
    for (int i = 0; i < 5; i++) begin
      add(1, 4'b0001, 4'b0000, 0, 4'b0001, 0, 2'd3, 0, 0, 8'd3, seq[i]);
      add(1, 4'b1100, 4'b0000, 0, 4'b0001, 0, 2'd3, 0, 0, 8'd3, seq[i]);
    end

    reset = 1'b1;
    {open_poll, ballot_release, close_poll, next_result} = 4'b0000;
    v = 4'b0000; cast_ready = 1'b0;
    tick(2);
    check("reset_state", 32'(outs()), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      {open_poll, ballot_release, close_poll, next_result} = vq[i].btn;
      v = vq[i].v;
      cast_ready = vq[i].rdy;
      tick(vq[i].n);
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vq[i].lamps, vq[i].cv, vq[i].idx, vq[i].inv, vq[i].tp, vq[i].bc, vq[i].rs}));
    end
    {open_poll, ballot_release, close_poll, next_result} = 4'b0000;

    // backpressure: cast held stable for 7 cycles, single transfer
    reset = 1'b1; tick(1); reset = 1'b0; tick(1);
    open_poll = 1'b1; tick(1); open_poll = 1'b0;
    ballot_release = 1'b1; tick(1); ballot_release = 1'b0;
    v = 4'b0010; tick(1);
    check("cast_start", 32'({cast_valid, cast_idx, busy}), 32'({1'b1, 2'd1, 1'b1}));
    for (int i = 0; i < 7; i++) begin
      tick(1);
      check($sformatf("cast_hold%0d", i), 32'({cast_valid, cast_idx, ballots_cast}),
            32'({1'b1, 2'd1, 8'd0}));
    end
    cast_ready = 1'b1; tick(1);
    check("cast_xfer", 32'({cast_valid, busy, ballots_cast}), 32'({1'b0, 1'b1, 8'd1}));
    cast_ready = 1'b0; v = 4'b0000; tick(16);
    check("lock_exit", 32'({ready_lamp, busy}), 32'({1'b1, 1'b0}));

    // reset during CAST with open_poll held
    ballot_release = 1'b1; tick(1); ballot_release = 1'b0;
    v = 4'b1000; tick(1);
    check("cast_again", 32'({cast_valid, cast_idx}), 32'({1'b1, 2'd3}));
    #2;
    open_poll = 1'b1; reset = 1'b1;
    #1;
    check("async_abort", 32'({cast_valid, busy, cast_idx, ballots_cast}), 32'd0);
    v = 4'b0000;
    tick(2); reset = 1'b0; tick(3);
    check("no_spurious_open", 32'(outs()), 32'd0);
    open_poll = 1'b0; tick(1); open_poll = 1'b1; tick(1); open_poll = 1'b0;
    check("open_after_reset", 32'({ready_lamp, armed_lamp}), 32'({1'b1, 1'b0}));

    // ballots_cast saturation
    for (int i = 0; i < 255; i++) do_cast();
    check("bc_255", 32'({ready_lamp, ballots_cast}), 32'({1'b1, 8'd255}));
    do_cast();
    check("bc_saturate", 32'({ready_lamp, ballots_cast}), 32'({1'b1, 8'd255}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
